// File: rtl/pipe_pkg.sv
// Shared types and default sizes for the pixel pipeline.
// Holds the pixel type, FSM states and shift-register operations.
package pipe_pkg;

  localparam int PIXEL_W  = 24;
  localparam int TAPS     = 5;
  localparam int LINE_LEN = 640;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  typedef enum logic [1:0] {
    SR_HOLD,
    SR_LOAD,
    SR_WRITE,
    SR_SHIFT
  } sr_op_t;

endpackage

// File: rtl/window_shift_reg.sv
// TAPS-deep pixel shift register for the window assembler.
// Ports: op/idx/din select load, write or shift; sr_nxt is the next contents.
module window_shift_reg #(
  parameter  int PIXEL_W = pipe_pkg::PIXEL_W,
  parameter  int TAPS    = pipe_pkg::TAPS,
  localparam int IW      = $clog2(TAPS)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  pipe_pkg::sr_op_t   op,
  input  logic [IW-1:0]      idx,
  input  logic [PIXEL_W-1:0] din,
  output logic [PIXEL_W-1:0] sr_last,
  output logic [PIXEL_W-1:0] sr_nxt [TAPS]
);
  import pipe_pkg::*;

  localparam int R = (TAPS - 1) / 2;

  logic [PIXEL_W-1:0] sr [TAPS];

  assign sr_last = sr[TAPS-1];

  // sr_nxt is also what the output register captures
  always_comb begin
    sr_nxt = sr;
    unique case (op)
      SR_LOAD: begin
        for (int i = 0; i < TAPS; i++)
          if (i <= R) sr_nxt[i] = din;
      end
      SR_WRITE: begin
        for (int i = 0; i < TAPS; i++)
          if (idx == IW'(i)) sr_nxt[i] = din;
      end
      SR_SHIFT: begin
        for (int i = 0; i < TAPS - 1; i++)
          sr_nxt[i] = sr[i+1];
        sr_nxt[TAPS-1] = din;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) sr <= '{default: '0};
    else          sr <= sr_nxt;
  end

endmodule

// File: rtl/pixel_window_assembler.sv
// Builds edge-replicated TAPS-wide horizontal windows from a pixel stream.
// Ports: in_* valid/ready pixel input, out_* window output, line_err sticky.
module pixel_window_assembler #(
  parameter  int PIXEL_W  = pipe_pkg::PIXEL_W,
  parameter  int TAPS     = pipe_pkg::TAPS,
  parameter  int LINE_LEN = pipe_pkg::LINE_LEN,
  localparam int CW       = $clog2(LINE_LEN)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIXEL_W-1:0] in_pixel,
  input  logic               in_sol,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PIXEL_W-1:0] out_pixels [TAPS],
  output logic [CW-1:0]      out_col,
  output logic               out_eol,
  output logic               line_err
);
  import pipe_pkg::*;

  localparam int R  = (TAPS - 1) / 2;
  localparam int IW = $clog2(TAPS);
  localparam int NW = $clog2(LINE_LEN + 1);
  localparam int FW = $clog2(R + 1);

  state_t             st, st_d;
  logic [NW-1:0]      n, n_d;
  logic [FW-1:0]      fc, fc_d;
  sr_op_t             op;
  logic [IW-1:0]      wr_idx;
  logic [PIXEL_W-1:0] din;
  logic [PIXEL_W-1:0] sr_last;
  logic [PIXEL_W-1:0] sr_nxt [TAPS];
  logic               slot_free, acc;
  logic               ld, first, last, err_set;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = reset_n && (st != FLUSH) && slot_free;
  assign acc       = in_valid && in_ready;
  assign wr_idx    = IW'(R) + IW'(n);

  window_shift_reg #(
    .PIXEL_W (PIXEL_W),
    .TAPS    (TAPS)
  ) u_sr (
    .clock   (clock),
    .reset_n (reset_n),
    .op      (op),
    .idx     (wr_idx),
    .din     (din),
    .sr_last (sr_last),
    .sr_nxt  (sr_nxt)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_d;
  end

  always_comb begin
    st_d    = st;
    n_d     = n;
    fc_d    = fc;
    op      = SR_HOLD;
    din     = in_pixel;
    ld      = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
    err_set = 1'b0;
    unique case (st)
      IDLE: begin
        if (acc && in_sol) begin
          op   = SR_LOAD;
          n_d  = NW'(1);
          st_d = FILL;
        end
      end
      FILL, RUN: begin
        if (acc && in_sol) begin
          // new line mid-line: drop the partial one, no flush
          err_set = 1'b1;
          op      = SR_LOAD;
          n_d     = NW'(1);
          st_d    = FILL;
        end else if (acc) begin
          n_d = n + NW'(1);
          if (st == FILL) begin
            op = SR_WRITE;
            if (n_d == NW'(TAPS - R)) begin
              ld    = 1'b1;
              first = 1'b1;
              st_d  = RUN;
            end
          end else begin
            op = SR_SHIFT;
            ld = 1'b1;
            if (n_d == NW'(LINE_LEN)) begin
              st_d = FLUSH;
              fc_d = '0;
            end
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          op   = SR_SHIFT;
          din  = sr_last;
          ld   = 1'b1;
          fc_d = fc + FW'(1);
          if (fc == FW'(R - 1)) begin
            last = 1'b1;
            st_d = IDLE;
            n_d  = '0;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      n          <= '0;
      fc         <= '0;
      out_valid  <= 1'b0;
      out_pixels <= '{default: '0};
      out_col    <= '0;
      out_eol    <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      n  <= n_d;
      fc <= fc_d;
      if (ld) begin
        out_valid  <= 1'b1;
        out_pixels <= sr_nxt;
        out_col    <= first ? '0 : out_col + CW'(1);
        out_eol    <= last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (err_set) line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_window_assembler.sv
// Directed bench for pixel_window_assembler, LINE_LEN=8, TAPS=5.
// Windows are captured at each output handshake and checked per scenario.
module tb_pixel_window_assembler;

  typedef struct packed {
    logic [119:0] w;
    logic [2:0]   col;
    logic         eol;
  } win_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_pixel = '0;
  logic        in_sol = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] opx [5];
  logic [2:0]  out_col;
  logic        out_eol;
  logic        line_err;

  int   nvec = 0;
  int   nerr = 0;
  int   omode = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  bit   hold_pend = 1'b0;
  win_t held;
  win_t got [$];

  logic [23:0] la [8];
  logic [23:0] lb [8];
  logic [23:0] lc [8];

  pixel_window_assembler #(
    .PIXEL_W  (24),
    .TAPS     (5),
    .LINE_LEN (8)
  ) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sol     (in_sol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixels (opx),
    .out_col    (out_col),
    .out_eol    (out_eol),
    .line_err   (line_err)
  );

  always #5 clk = ~clk;

  function automatic win_t cur_win();
    win_t r;
    for (int i = 0; i < 5; i++) r.w[24*i +: 24] = opx[i];
    r.col = out_col;
    r.eol = out_eol;
    return r;
  endfunction

  // reference window: clamp column indices into the line
  function automatic logic [119:0] win_of(input logic [23:0] a [8],
                                          input int c);
    logic [119:0] w;
    int j;
    for (int i = 0; i < 5; i++) begin
      j = c - 2 + i;
      if (j < 0) j = 0;
      if (j > 7) j = 7;
      w[24*i +: 24] = a[j];
    end
    return w;
  endfunction

  task automatic step(input bit v, input bit sol, input logic [23:0] px,
                      output bit acc);
    win_t cw;
    @(negedge clk);
    in_valid  = v;
    in_sol    = sol;
    in_pixel  = px;
    out_ready = (omode == 1) ? ((cyc % 2) == 0) : 1'b1;
    #1;
    cw = cur_win();
    if (hold_pend) begin
      nvec++;
      if (!out_valid || cw !== held) begin
        nerr++;
        $display("FAIL stall_hold: got %h want %h", cw, held);
      end
    end
    if (out_valid && !out_ready) begin
      nvec++;
      if (in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL ready_in_stall: got %b want 0", in_ready);
      end
    end
    hold_pend = out_valid && !out_ready;
    held = cw;
    if (out_valid && out_ready) got.push_back(cw);
    if (v && !in_ready) stall_cnt++;
    acc = v && in_ready;
    cyc++;
  endtask

  task automatic send_pix(input logic [23:0] px, input bit sol);
    bit a;
    int k;
    a = 1'b0;
    k = 0;
    while (!a && k < 50) begin
      step(1'b1, sol, px, a);
      k++;
    end
    if (!a) begin
      nvec++;
      nerr++;
      $display("FAIL accept_timeout: got none want accept of %0d", px);
    end
  endtask

  task automatic send_line(input logic [23:0] a [8]);
    for (int i = 0; i < 8; i++) send_pix(a[i], i == 0);
  endtask

  task automatic drain(input int cnt);
    bit a;
    int k;
    k = 0;
    while (got.size() < cnt && k < 200) begin
      step(1'b0, 1'b0, 24'd0, a);
      k++;
    end
    nvec++;
    if (got.size() < cnt) begin
      nerr++;
      $display("FAIL drain_timeout: got %0d windows want %0d",
               got.size(), cnt);
    end
    in_valid = 1'b0;
    in_sol   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    hold_pend = 1'b0;
    cyc       = 0;
    got.delete();
  endtask

  task automatic check_line(input string nm, input logic [23:0] a [8],
                            input int base);
    for (int c = 0; c < 8; c++) begin
      nvec++;
      if (base + c >= got.size() ||
          got[base+c].w !== win_of(a, c) ||
          got[base+c].col !== 3'(c) ||
          got[base+c].eol !== (c == 7)) begin
        nerr++;
        $display("FAIL %s col%0d: got %h want %h/%0d/%0d", nm, c,
                 (base + c < got.size()) ? got[base+c] : '0,
                 win_of(a, c), c, (c == 7));
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || line_err !== 1'b0 ||
        out_col !== 3'd0 || out_eol !== 1'b0 || opx[0] !== 24'd0 ||
        opx[4] !== 24'd0) begin
      nerr++;
      $display("FAIL reset: got v%b r%b e%b c%0d eol%b p0 %h want all 0",
               out_valid, in_ready, line_err, out_col, out_eol, opx[0]);
    end
    rst_n = 1'b1;
    hold_pend = 1'b0;
  endtask

  task automatic test_basic();
    logic [119:0] k0, k7;
    omode = 0;
    got.delete();
    send_line(la);
    drain(8);
    nvec++;
    if (got.size() !== 8) begin
      nerr++;
      $display("FAIL basic_count: got %0d want 8", got.size());
    end
    k0 = {24'd3, 24'd2, 24'd1, 24'd1, 24'd1};
    k7 = {24'd8, 24'd8, 24'd8, 24'd7, 24'd6};
    nvec++;
    if (got.size() < 8 || got[0].w !== k0 || got[7].w !== k7) begin
      nerr++;
      $display("FAIL basic_edges: got %h/%h want %h/%h",
               (got.size() > 0) ? got[0].w : '0,
               (got.size() > 7) ? got[7].w : '0, k0, k7);
    end
    check_line("basic", la, 0);
    nvec++;
    if (line_err !== 1'b0) begin
      nerr++;
      $display("FAIL basic_err: got %b want 0", line_err);
    end
  endtask

  task automatic test_stall();
    omode = 1;
    got.delete();
    send_line(la);
    drain(8);
    omode = 0;
    nvec++;
    if (got.size() !== 8) begin
      nerr++;
      $display("FAIL stall_count: got %0d want 8", got.size());
    end
    check_line("stall", la, 0);
  endtask

  task automatic test_drop();
    omode = 0;
    got.delete();
    send_pix(24'd9, 1'b0);
    send_pix(24'd9, 1'b0);
    send_line(la);
    drain(8);
    nvec++;
    if (got.size() !== 8) begin
      nerr++;
      $display("FAIL drop_count: got %0d want 8", got.size());
    end
    check_line("drop", la, 0);
  endtask

  task automatic test_error();
    omode = 0;
    got.delete();
    for (int i = 0; i < 4; i++) send_pix(la[i], i == 0);
    send_line(lc);
    drain(10);
    nvec++;
    if (line_err !== 1'b1) begin
      nerr++;
      $display("FAIL err_flag: got %b want 1", line_err);
    end
    nvec++;
    if (got.size() !== 10) begin
      nerr++;
      $display("FAIL err_count: got %0d want 10", got.size());
    end
    nvec++;
    if (got.size() < 2 || got[0].w !== win_of(la, 0) ||
        got[1].w !== win_of(la, 1)) begin
      nerr++;
      $display("FAIL err_partial: got %h want %h",
               (got.size() > 0) ? got[0].w : '0, win_of(la, 0));
    end
    check_line("err_restart", lc, 2);
  endtask

  task automatic test_back_to_back();
    do_reset();
    omode = 0;
    send_line(la);
    stall_cnt = 0;
    send_line(lb);
    nvec++;
    if (stall_cnt !== 2) begin
      nerr++;
      $display("FAIL b2b_flush_gap: got %0d want 2", stall_cnt);
    end
    drain(16);
    nvec++;
    if (got.size() !== 16) begin
      nerr++;
      $display("FAIL b2b_count: got %0d want 16", got.size());
    end
    check_line("b2b_l1", la, 0);
    check_line("b2b_l2", lb, 8);
  endtask

  task automatic test_reset_mid();
    do_reset();
    omode = 0;
    send_pix(la[0], 1'b1);
    send_pix(la[1], 1'b0);
    for (int i = 0; i < 5; i++) send_pix(la[i], i == 0);
    nvec++;
    if (line_err !== 1'b1) begin
      nerr++;
      $display("FAIL mid_err_pre: got %b want 1", line_err);
    end
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sol   = 1'b0;
    #1;
    nvec++;
    if (in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL mid_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || line_err !== 1'b0 || out_col !== 3'd0) begin
      nerr++;
      $display("FAIL mid_reset: got v%b e%b c%0d want 0 0 0",
               out_valid, line_err, out_col);
    end
    hold_pend = 1'b0;
    got.delete();
    send_line(lb);
    drain(8);
    nvec++;
    if (got.size() !== 8) begin
      nerr++;
      $display("FAIL mid_count: got %0d want 8", got.size());
    end
    check_line("mid_line", lb, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      la[i] = 24'(i + 1);
      lb[i] = 24'(i + 11);
      lc[i] = 24'(i + 20);
    end
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
